// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Operands are reduced to magnitudes at capture; one shift-add (multiply) or
// restoring (divide) step runs per cycle for XLEN cycles, the sign is applied
// on the final step, and the write-back fields are registered with DONE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r, state_nx_s;
  logic [CW-1:0]       count_r;
  logic [2:0]          op_r;
  logic [4:0]          rd_r;
  logic [XLEN-1:0]     opnd_r;     // multiplicand (MUL*) or divisor (DIV*/REM*)
  logic [2*XLEN-1:0]   acc_r;      // {partial product | remainder, multiplier | quotient}
  logic                neg_r;      // negate the selected result on finish

  logic                sgn1_s, sgn2_s, n1_s, n2_s, div_zero_s, neg_cap_s;
  logic [XLEN-1:0]     mag1_s, mag2_s, opnd_cap_s;
  logic [2*XLEN-1:0]   acc_cap_s, acc_nx_s, prod_s;
  logic [XLEN:0]       sum_s, top_s;
  logic [XLEN-1:0]     diff_s, res_s;
  logic                borrow_s, last_s;

  // Two's-complement negate when n is set (XLEN wide).
  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    neg_if = n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Two's-complement negate when n is set (2*XLEN wide).
  function automatic logic [2*XLEN-1:0] neg2_if(input logic n, input logic [2*XLEN-1:0] v);
    neg2_if = n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Capture decode: signedness, magnitudes and the sign to apply at finish.
  // Divide-by-zero keeps the quotient positive so DIV yields all ones; the
  // remainder naturally equals the dividend. DIV overflow needs no override:
  // |-2^(XLEN-1)| / 1 with matching signs already gives -2^(XLEN-1), rem 0.
  always_comb begin
    sgn1_s = 1'b0;
    sgn2_s = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd4, 3'd6: begin sgn1_s = 1'b1; sgn2_s = 1'b1; end
      3'd2:                   begin sgn1_s = 1'b1; sgn2_s = 1'b0; end
      default:                begin sgn1_s = 1'b0; sgn2_s = 1'b0; end
    endcase
    n1_s       = sgn1_s & rs1_val[XLEN-1];
    n2_s       = sgn2_s & rs2_val[XLEN-1];
    mag1_s     = neg_if(n1_s, rs1_val);
    mag2_s     = neg_if(n2_s, rs2_val);
    div_zero_s = (rs2_val == {XLEN{1'b0}});
    case (op)
      3'd4, 3'd5: neg_cap_s = (n1_s ^ n2_s) & ~div_zero_s;
      3'd6, 3'd7: neg_cap_s = n1_s;
      default:    neg_cap_s = n1_s ^ n2_s;
    endcase
    if (op[2]) begin
      opnd_cap_s = mag2_s;
      acc_cap_s  = {{XLEN{1'b0}}, mag1_s};
    end else begin
      opnd_cap_s = mag1_s;
      acc_cap_s  = {{XLEN{1'b0}}, mag2_s};
    end
  end

  // One iteration step and the finished result derived from it.
  always_comb begin
    sum_s    = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, (acc_r[0] ? opnd_r : {XLEN{1'b0}})};
    top_s    = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    borrow_s = (top_s < {1'b0, opnd_r});
    diff_s   = top_s[XLEN-1:0] - opnd_r;
    if (op_r[2]) begin
      if (borrow_s) begin
        acc_nx_s = {top_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end else begin
        acc_nx_s = {diff_s, acc_r[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_nx_s = {sum_s, acc_r[XLEN-1:1]};
    end
    prod_s = neg2_if(neg_r, acc_nx_s);
    case (op_r)
      3'd0:       res_s = prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       res_s = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5: res_s = neg_if(neg_r, acc_nx_s[XLEN-1:0]);
      3'd6, 3'd7: res_s = neg_if(neg_r, acc_nx_s[2*XLEN-1:XLEN]);
      default:    res_s = {XLEN{1'b0}};
    endcase
    last_s = (count_r == CW'(XLEN - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: IDLE -> CALC on start, CALC -> DONE after XLEN steps, DONE -> IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_CALC;
        else       state_nx_s = ST_IDLE;
      end
      ST_CALC: begin
        if (last_s) state_nx_s = ST_DONE;
        else        state_nx_s = ST_CALC;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs: capture, iterate, publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
      op_r    <= 3'd0;
      rd_r    <= 5'd0;
      opnd_r  <= {XLEN{1'b0}};
      acc_r   <= {(2*XLEN){1'b0}};
      neg_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wb_we   <= 1'b0;
      wb_addr <= 5'd0;
      wb_data <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r    <= op;
            rd_r    <= rd_addr;
            opnd_r  <= opnd_cap_s;
            acc_r   <= acc_cap_s;
            neg_r   <= neg_cap_s;
            count_r <= {CW{1'b0}};
            busy    <= 1'b1;
          end
        end
        ST_CALC: begin
          acc_r   <= acc_nx_s;
          count_r <= count_r + CW'(1);
          if (last_s) begin
            done    <= 1'b1;
            wb_we   <= (rd_r != 5'd0);
            wb_addr <= rd_r;
            wb_data <= res_s;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          wb_we <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          done  <= 1'b0;
          wb_we <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a behavioural model (plain 64-bit
// arithmetic plus a cycle-level latency model) is compared against every
// output on every falling edge; directed vectors pin the model to literals.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] rs1_val = '0;
  logic [XLEN-1:0] rs2_val = '0;
  logic [4:0]      rd_addr = 5'd0;
  logic            busy, done, wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .busy(busy), .done(done), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic signed [31:0] sa, sb, sq;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[31:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sq = sa / sb; return sq;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sq = sa % sb; return sq;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycle-level model: request accepted only when idle, DONE XLEN edges later.
  logic        m_busy = 1'b0, m_done = 1'b0, m_we = 1'b0;
  logic [4:0]  m_addr = 5'd0, m_rd = 5'd0;
  logic [31:0] m_data = 32'd0, m_res = 32'd0;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_we <= 1'b0;
      m_addr <= 5'd0; m_data <= 32'd0; m_cnt <= 0;
    end else if (m_done) begin
      m_done <= 1'b0; m_we <= 1'b0; m_busy <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == XLEN - 1) begin
        m_done <= 1'b1; m_we <= (m_rd != 5'd0); m_addr <= m_rd; m_data <= m_res;
      end
    end else if (start) begin
      m_busy <= 1'b1; m_cnt <= 0; m_rd <= rd_addr;
      m_res <= ref_result(op, rs1_val, rs2_val);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("wb_we", {31'd0, wb_we}, {31'd0, m_we});
    check("wb_addr", {27'd0, wb_addr}, {27'd0, m_addr});
    check("wb_data", wb_data, m_data);
    if (done) done_cnt++;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // One operation: checks latency, write-back and single DONE; optional START poke mid-CALC.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit poke);
    int n;
    bit seen;
    int d0;
    d0 = done_cnt;
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_addr = rd;
    tick();
    start = 1'b0; op = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_addr = 5'($urandom);
    n = 1;
    seen = 1'b0;
    while (!seen && n < XLEN + 8) begin
      start = (poke && n == 5);
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'(XLEN + 1));
    check("result", wb_data, exp);
    check("we", {31'd0, wb_we}, {31'd0, (rd != 5'd0)});
    check("addr", {27'd0, wb_addr}, {27'd0, rd});
    tick();
    tick();
    check("done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  logic [2:0]  v_op [14];
  logic [31:0] v_a  [14];
  logic [31:0] v_b  [14];
  logic [31:0] v_e  [14];

  initial begin
    v_op[0]  = 3'd0; v_a[0]  = 32'd7;          v_b[0]  = 32'hFFFF_FFFD; v_e[0]  = 32'hFFFF_FFEB;
    v_op[1]  = 3'd1; v_a[1]  = 32'h8000_0000;  v_b[1]  = 32'h8000_0000; v_e[1]  = 32'h4000_0000;
    v_op[2]  = 3'd3; v_a[2]  = 32'hFFFF_FFFF;  v_b[2]  = 32'hFFFF_FFFF; v_e[2]  = 32'hFFFF_FFFE;
    v_op[3]  = 3'd2; v_a[3]  = 32'hFFFF_FFFF;  v_b[3]  = 32'hFFFF_FFFF; v_e[3]  = 32'hFFFF_FFFF;
    v_op[4]  = 3'd4; v_a[4]  = 32'hFFFF_FFF9;  v_b[4]  = 32'd2;         v_e[4]  = 32'hFFFF_FFFD;
    v_op[5]  = 3'd6; v_a[5]  = 32'hFFFF_FFF9;  v_b[5]  = 32'd2;         v_e[5]  = 32'hFFFF_FFFF;
    v_op[6]  = 3'd5; v_a[6]  = 32'd100;        v_b[6]  = 32'd7;         v_e[6]  = 32'd14;
    v_op[7]  = 3'd7; v_a[7]  = 32'd100;        v_b[7]  = 32'd7;         v_e[7]  = 32'd2;
    v_op[8]  = 3'd4; v_a[8]  = 32'd5;          v_b[8]  = 32'd0;         v_e[8]  = 32'hFFFF_FFFF;
    v_op[9]  = 3'd6; v_a[9]  = 32'd5;          v_b[9]  = 32'd0;         v_e[9]  = 32'd5;
    v_op[10] = 3'd4; v_a[10] = 32'h8000_0000;  v_b[10] = 32'hFFFF_FFFF; v_e[10] = 32'h8000_0000;
    v_op[11] = 3'd6; v_a[11] = 32'h8000_0000;  v_b[11] = 32'hFFFF_FFFF; v_e[11] = 32'd0;
    v_op[12] = 3'd5; v_a[12] = 32'd5;          v_b[12] = 32'd0;         v_e[12] = 32'hFFFF_FFFF;
    v_op[13] = 3'd7; v_a[13] = 32'hDEAD_BEEF;  v_b[13] = 32'd0;         v_e[13] = 32'hDEAD_BEEF;

    // Reset state.
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Pin the model to hand-computed values, then run the same vectors through the DUT.
    for (int i = 0; i < 14; i++) begin
      check("model", ref_result(v_op[i], v_a[i], v_b[i]), v_e[i]);
      run_op(v_op[i], v_a[i], v_b[i], (i == 0) ? 5'd5 : 5'(i + 1), v_e[i], 1'b0);
    end

    // rd=0 runs but does not write; a START poke during CALC is ignored.
    run_op(3'd0, 32'd6, 32'd9, 5'd0, 32'd54, 1'b0);
    run_op(3'd5, 32'd1000, 32'd10, 5'd17, 32'd100, 1'b1);

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd9;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, wb_we}, 32'd0);
    check("rst_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_data", wb_data, 32'd0);
    tick();
    rst_n = 1'b1;
    begin
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < XLEN + 6; i++) tick();
      check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    end
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd12, 32'hFFFF_FFFF, 1'b0);

    // Random traffic: START asserted at random, including during CALC and DONE.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op = 3'($urandom);
      rs1_val = pick();
      rs2_val = pick();
      rd_addr = 5'($urandom);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < XLEN + 4; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
